truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Self-checking stimulus and capture stage that sits directly upstream and downstream of a single 3-input combinational truth-table gate. It drives the gate's `in1`/`in2`/`in3` through all eight input rows and waits a programmable settle time per row. It majority-samples the gate output and assembles the measured 8-bit truth-table word, then compares that word against an expected code and reports pass/fail. It is used for on-chip characterization of synthesized logic gates.

## Interface
- `SETTLE_CYCLES`, 4: cycles each row is held before sampling; legal range 1..255.
- `SAMPLES`, 3: consecutive output samples per row, majority-voted; odd only, 1..7.
- `EXPECTED`, 8'hD9: expected truth-table word.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begins a sweep when sampled high in IDLE.
- `abort` input 1: cancels a sweep in progress.
- `gate_out` input 1: output of the gate under test.
- `in1`, `in2`, `in3` output 1 each: registered gate inputs, with row index = {in1,in2,in3}.
- `busy` output 1: high from the first APPLY cycle until `done`, inclusive.
- `done` output 1: one-cycle pulse when the sweep completes.
- `table_word` output 8: measured word; row r result is stored in bit (7 − r).
- `pass` output 1: `table_word == EXPECTED`, valid from `done`.
- `mismatch` output 8: `table_word ^ EXPECTED`.

## Operation
- States are IDLE, SETTLE, SAMPLE and DONE.
- IDLE to SETTLE:
  - Occurs on `start` and not `abort`.
  - Row is 0 and {in1,in2,in3} = 000.
  - Settle counter and vote counter are cleared.
- SETTLE:
  - Counts `SETTLE_CYCLES` cycles and ignores `gate_out`.
  - Then moves to SAMPLE.
- SAMPLE:
  - Counts `gate_out` ones over `SAMPLES` cycles.
  - After the last sample, the bit is set if ones > SAMPLES/2 and is written to the working word bit (7 − row).
  - If row < 7: increment the row, drive the new row on the inputs, and return to SETTLE.
  - If row = 7: go to DONE.
- DONE (one cycle):
  - The working word is copied to `table_word`; `pass` and `mismatch` update.
  - `done` = 1.
  - Inputs return to 000.
  - Next state is IDLE.
- Results hold until the next completed sweep. A sweep that does not complete (abort or reset) never partially updates them.
- `start` while busy is ignored.
- `abort` in any non-IDLE state:
  - Returns to IDLE on the next edge and inputs go to 000.
  - No `done` pulse; results are unchanged.
- `abort` and `start` together in IDLE: `abort` wins and the block stays in IDLE.
- Vote counter width is 3 bits; settle counter width is 8 bits. No overflow is possible within the legal parameter ranges.

## Timing
- Reset values: `in1`/`in2`/`in3` = 0, `busy` = 0, `done` = 0, `table_word` = 0, `pass` = 0, `mismatch` = 0, state IDLE.
- Reset mid-sweep discards all progress immediately (asynchronous).
- Let `start` be accepted at edge 0, and P = SETTLE_CYCLES + SAMPLES.
  - Row r is driven during cycles 1 + r·P through (r+1)·P.
  - Samples for row r are taken in the last `SAMPLES` of those cycles.
  - `done` is high in cycle 1 + 8·P, which is cycle 57 with the defaults.
  - The next `start` is accepted in cycle 2 + 8·P at the earliest.
- All outputs are registered; there is no combinational path from `gate_out` to any output.

## Structure
- Shared package `cello_tt_pkg` holds:
  - the state enum `tt_state_e`;
  - `NUM_ROWS = 8`;
  - the row index type `tt_row_t` (3 bits);
  - the bit-mapping helper function (row r → bit 7 − r).
- Sub-module `tt_majority_sampler` contains:
  - the vote counter;
  - clear/enable inputs;
  - a one-cycle `vote_valid` output with the `vote_bit` result.
- The top level holds the FSM, settle counter, row counter and result registers.

## Test plan
- Connect the reference `0xD9` gate model and pulse `start` → in1..3 step through 000..111 on the cycles above; `done` at cycle 57, `table_word` = 8'hD9, `pass` = 1, `mismatch` = 0.
- Tie `gate_out` = 0 → `table_word` = 8'h00, `pass` = 0, `mismatch` = 8'hD9.
- Force `gate_out` high for only one cycle within the row-2 sample window of the D9 model (SAMPLES = 3), where row 2 should read 0 → majority rejects the glitch and `table_word` = 8'hD9.
- After one passing sweep, assert `abort` at cycle 20 of a second sweep → IDLE next cycle, inputs 000, no `done`, `table_word` stays 8'hD9.
- Hold `start` high continuously and pulse `start` and `abort` together in IDLE → exactly one sweep per IDLE entry; the simultaneous case starts nothing.
- Deassert `rst_n` mid-sweep (cycle 30) → all outputs 0 immediately; after release, a fresh sweep gives 8'hD9.

Source files
------------

// File: rtl/cello_tt_pkg.sv
// Shared definitions for the truth-table sweeper.
// Holds the FSM state encoding, the row count, the row index type and
// the mapping from a row index to its bit position in the measured word.
package cello_tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } tt_state_e;

    localparam int NUM_ROWS = 8;

    typedef logic [2:0] tt_row_t;

    // Row 0 lands in the MSB so the word reads like a truth table listed
    // top-down from input 000.
    function automatic logic [2:0] row_to_bit(input tt_row_t row);
        return 3'(NUM_ROWS - 1) - row;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bundle of the sweeper's control, gate-under-test and result signals.
//   master : sweep controller / environment side (drives start, abort,
//            gate_out; observes gate inputs and results)
//   slave  : the sweeper itself
interface truth_table_sweeper_if;

    logic       start;
    logic       abort;
    logic       gate_out;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       busy;
    logic       done;
    logic [7:0] table_word;
    logic       pass;
    logic [7:0] mismatch;

    modport master (
        output start, abort, gate_out,
        input  in1, in2, in3, busy, done, table_word, pass, mismatch
    );

    modport slave (
        input  start, abort, gate_out,
        output in1, in2, in3, busy, done, table_word, pass, mismatch
    );

endinterface

// File: rtl/tt_majority_sampler.sv
// Majority voter for one truth-table row.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : drop any partial vote (used whenever not sampling)
//   enable      : take one sample of sample_in this cycle
//   sample_in   : gate output being characterised
//   vote_valid  : high in the cycle the last of SAMPLES samples is taken
//   vote_bit    : majority result, valid with vote_valid
// The verdict includes the current cycle's sample, so it is ready on the
// same edge that takes the last sample; it only ever feeds registers.
module tt_majority_sampler #(
    parameter int SAMPLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic sample_in,
    output logic vote_valid,
    output logic vote_bit
);

    localparam logic [2:0] LAST_IDX = 3'(SAMPLES - 1);
    localparam logic [2:0] HALF     = 3'(SAMPLES / 2);

    logic [2:0] idx_q, idx_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] ones_total;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path through the branches can leave it unassigned and infer a latch.
    always_comb begin
        ones_total = ones_q + {2'b00, sample_in};
        idx_d      = idx_q;
        ones_d     = ones_q;
        vote_valid = 1'b0;
        vote_bit   = 1'b0;
        if (clear) begin
            idx_d  = '0;
            ones_d = '0;
        end else if (enable) begin
            if (idx_q == LAST_IDX) begin
                vote_valid = 1'b1;
                vote_bit   = (ones_total > HALF);
                idx_d      = '0;
                ones_d     = '0;
            end else begin
                idx_d  = idx_q + 3'd1;
                ones_d = ones_total;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments and reset
    // asynchronously; combinational next-state logic uses blocking ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            ones_q <= '0;
        end else begin
            idx_q  <= idx_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input gate under test through all eight input rows, lets each
// row settle, majority-samples the gate output and assembles the measured
// truth-table word, then compares it with EXPECTED.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/abort control, gate_out from the gate, registered
//                gate inputs in1..in3, busy/done status and results
//                (table_word, pass, mismatch)
// Results only change when a sweep completes; abort and reset never leave
// a partially updated word behind.
module truth_table_sweeper
    import cello_tt_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 4,
    parameter int         SAMPLES       = 3,
    parameter logic [7:0] EXPECTED      = 8'hD9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    truth_table_sweeper_if.slave        bus
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam tt_row_t    LAST_ROW    = 3'(NUM_ROWS - 1);

    tt_state_e  state_q, state_d;
    logic [7:0] settle_q, settle_d;
    tt_row_t    row_q, row_d;
    logic [7:0] word_q, word_d;
    logic [7:0] table_q, table_d;
    logic       pass_q, pass_d;
    logic [7:0] mismatch_q, mismatch_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       vote_valid;
    logic       vote_bit;
    logic       sampling;

    assign sampling = (state_q == ST_SAMPLE);

    tt_majority_sampler #(
        .SAMPLES (SAMPLES)
    ) u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (!sampling),
        .enable     (sampling),
        .sample_in  (bus.gate_out),
        .vote_valid (vote_valid),
        .vote_bit   (vote_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Abort beats everything, including a start in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (bus.start && !bus.abort) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (bus.abort)                   state_d = ST_IDLE;
                else if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (bus.abort)                   state_d = ST_IDLE;
                else if (vote_valid)             state_d = (row_q == LAST_ROW) ? ST_DONE : ST_SETTLE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath / output logic. Results are loaded on the edge into DONE so
    // that table_word, pass and mismatch are already valid while done is high.
    always_comb begin
        settle_d   = settle_q;
        row_d      = row_q;
        word_d     = word_q;
        table_d    = table_q;
        pass_d     = pass_q;
        mismatch_d = mismatch_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    settle_d = '0;
                    row_d    = '0;
                    word_d   = '0;
                    busy_d   = 1'b1;
                end
            end
            ST_SETTLE: begin
                settle_d = (settle_q == SETTLE_LAST) ? 8'd0 : settle_q + 8'd1;
            end
            ST_SAMPLE: begin
                if (vote_valid) begin
                    word_d[row_to_bit(row_q)] = vote_bit;
                    if (row_q == LAST_ROW) begin
                        table_d    = word_d;
                        pass_d     = (word_d == EXPECTED);
                        mismatch_d = word_d ^ EXPECTED;
                        done_d     = 1'b1;
                        row_d      = '0;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
            end
            default: ;
        endcase

        if (bus.abort && (state_q != ST_IDLE)) begin
            settle_d   = '0;
            row_d      = '0;
            table_d    = table_q;
            pass_d     = pass_q;
            mismatch_d = mismatch_q;
            busy_d     = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q   <= '0;
            row_q      <= '0;
            word_q     <= '0;
            table_q    <= '0;
            pass_q     <= 1'b0;
            mismatch_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            settle_q   <= settle_d;
            row_q      <= row_d;
            word_q     <= word_d;
            table_q    <= table_d;
            pass_q     <= pass_d;
            mismatch_q <= mismatch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in1        = row_q[2];
    assign bus.in2        = row_q[1];
    assign bus.in3        = row_q[0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.table_word = table_q;
    assign bus.pass       = pass_q;
    assign bus.mismatch   = mismatch_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with defaults SETTLE_CYCLES=4,
// SAMPLES=3, EXPECTED=8'hD9. Cycle k is the cycle after start is taken on
// edge 0; outputs are observed on the falling edge inside that cycle.
module tb_truth_table_sweeper;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [7:0] model_word = 8'hD9;
    logic       zero_gate  = 1'b0;
    logic       glitch     = 1'b0;
    logic [2:0] row_in;

    truth_table_sweeper_if bus();

    assign row_in       = {bus.in1, bus.in2, bus.in3};
    assign bus.gate_out = zero_gate ? 1'b0 : (model_word[3'd7 - row_in] | glitch);

    truth_table_sweeper #(
        .SETTLE_CYCLES (4),
        .SAMPLES       (3),
        .EXPECTED      (8'hD9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full sweep with per-cycle checks of row sequencing, busy and done.
    task automatic run_sweep(input string tag, input logic [7:0] exp_word,
                             input logic exp_pass, input logic [7:0] exp_mis,
                             input int glitch_cycle);
        int bad_rows = 0;
        int bad_busy = 0;
        int done_cnt = 0;
        int done_at  = -1;
        int er;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            glitch = (k == glitch_cycle);
            er = (k <= 56) ? (k - 1) / 7 : 0;
            if (row_in != 3'(er)) bad_rows++;
            if (bus.busy != (k <= 57)) bad_busy++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k == 57) begin
                check({tag, "_word"}, 32'(bus.table_word), 32'(exp_word));
                check({tag, "_pass"}, 32'(bus.pass), 32'(exp_pass));
                check({tag, "_mismatch"}, 32'(bus.mismatch), 32'(exp_mis));
            end
        end
        glitch = 1'b0;
        check({tag, "_row_seq_errors"}, 32'(bad_rows), 32'd0);
        check({tag, "_busy_errors"}, 32'(bad_busy), 32'd0);
        check({tag, "_done_cycle"}, 32'(done_at), 32'd57);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int second_done;
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_inputs", 32'(row_in), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_word", 32'(bus.table_word), 32'd0);
        check("rst_pass", 32'(bus.pass), 32'd0);
        check("rst_mismatch", 32'(bus.mismatch), 32'd0);
        rst_n = 1'b1;

        // Reference D9 gate.
        run_sweep("d9", 8'hD9, 1'b1, 8'h00, 0);

        // Gate output stuck at 0.
        zero_gate = 1'b1;
        run_sweep("zero", 8'h00, 1'b0, 8'hD9, 0);
        zero_gate = 1'b0;

        // One-cycle glitch high in the row-2 sample window (cycles 19..21).
        run_sweep("glitch", 8'hD9, 1'b1, 8'h00, 20);

        // Abort at cycle 20 of a sweep after a passing one.
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy_after", 32'(bus.busy), 32'd0);
        check("abort_inputs", 32'(row_in), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_word_kept", 32'(bus.table_word), 32'hD9);
        check("abort_pass_kept", 32'(bus.pass), 32'd1);

        // start held high: one sweep per IDLE entry, next start at cycle 58.
        done_cnt    = 0;
        first_done  = -1;
        second_done = -1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
            if (k == 58) check("held_idle_gap_busy", 32'(bus.busy), 32'd0);
            if (k == 59) check("held_restart_busy", 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b0;
        check("held_done_count", 32'(done_cnt), 32'd2);
        check("held_first_done", 32'(first_done), 32'd57);
        check("held_second_done", 32'(second_done), 32'd115);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("held_abort_busy", 32'(bus.busy), 32'd0);

        // start and abort together in IDLE: nothing starts.
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("both_busy", 32'(bus.busy), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy || (row_in != 3'd0)) done_cnt++;
        end
        check("both_no_activity", 32'(done_cnt), 32'd0);

        // Asynchronous reset at cycle 30 of a sweep.
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        check("prerst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_inputs", 32'(row_in), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_word", 32'(bus.table_word), 32'd0);
        check("midrst_pass", 32'(bus.pass), 32'd0);
        check("midrst_mismatch", 32'(bus.mismatch), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep("post_rst", 8'hD9, 1'b1, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
